// File: rtl/sdram_test_pkg.sv
// rtl/sdram_test_pkg.sv - shared constants and FSM encoding for the SDRAM test design
package sdram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_FLUSH,
    ST_HALT
  } chk_state_e;

  localparam int          BURST_LEN_DEF = 8;
  localparam logic [15:0] PATTERN_SEED  = 16'h0000;
  localparam logic [15:0] ERR_CNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/sdram_rd_pattern_ref.sv
// rtl/sdram_rd_pattern_ref.sv - expected-pattern generator and word index counter
module sdram_rd_pattern_ref
  import sdram_test_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int TOTAL_LOG2 = 22
) (
  input  logic                  SYSCLK,
  input  logic                  RST_N,
  input  logic                  advance,
  output logic [DATA_W-1:0]     exp_data,
  output logic [TOTAL_LOG2-1:0] word_idx,
  output logic                  last_word
);

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_data <= DATA_W'(PATTERN_SEED);
      word_idx <= '0;
    end else if (advance) begin
      exp_data <= exp_data + DATA_W'(1);
      word_idx <= word_idx + TOTAL_LOG2'(1);
    end
  end

  assign last_word = &word_idx;

endmodule

// File: rtl/sdram_rd_check.sv
// rtl/sdram_rd_check.sv - drains the SDRAM read FIFO in bursts and checks the 0,1,2,... pattern
// Optional first-mismatch capture: define CHK_ERR_CAPTURE_EN.
module sdram_rd_check
  import sdram_test_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int TOTAL_LOG2  = 22,
  parameter int USEDW_W     = 9,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                  SYSCLK,
  input  logic                  RST_N,
  input  logic                  WR_DONE,
  input  logic [DATA_W-1:0]     RD_FIFO_DATA,
  input  logic [USEDW_W-1:0]    RD_FIFO_USEDW,
  output logic                  RD_FIFO_REQ,
  output logic                  CHK_BUSY,
  output logic                  CHK_DONE,
  output logic                  CHK_ERR,
  output logic [15:0]           ERR_CNT,
  output logic                  CHK_TIMEOUT,
  output logic [TOTAL_LOG2-1:0] ERR_FIRST_IDX,
  output logic [DATA_W-1:0]     ERR_FIRST_DATA
);

  localparam int BL_LOG2  = $clog2(BURST_LEN);
  localparam int BURSTS_W = TOTAL_LOG2 - BL_LOG2;
  localparam int IDLE_W   = $clog2(TIMEOUT_CYC + 1);

  chk_state_e            state, state_nxt;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [BL_LOG2-1:0]    beat_cnt;
  logic [BURSTS_W-1:0]   burst_num;
  logic                  rd_vld;
  logic                  fifo_ready, wd_expired, burst_end, last_burst, mismatch;
  logic [DATA_W-1:0]     exp_data;
  logic [TOTAL_LOG2-1:0] word_idx;
  logic                  last_word;

  assign fifo_ready = RD_FIFO_USEDW >= USEDW_W'(BURST_LEN);
  assign wd_expired = idle_cnt == IDLE_W'(TIMEOUT_CYC);
  assign burst_end  = beat_cnt == BL_LOG2'(BURST_LEN - 1);
  assign last_burst = &burst_num;
  assign mismatch   = rd_vld && (RD_FIFO_DATA != exp_data);

  sdram_rd_pattern_ref #(
    .DATA_W    (DATA_W),
    .TOTAL_LOG2(TOTAL_LOG2)
  ) u_ref (
    .SYSCLK   (SYSCLK),
    .RST_N    (RST_N),
    .advance  (rd_vld),
    .exp_data (exp_data),
    .word_idx (word_idx),
    .last_word(last_word)
  );

  always_comb begin
    state_nxt   = state;
    RD_FIFO_REQ = 1'b0;
    CHK_BUSY    = 1'b0;
    case (state)
      ST_IDLE:  if (WR_DONE) state_nxt = ST_WAIT;
      ST_WAIT: begin
        CHK_BUSY = 1'b1;
        if (fifo_ready)      state_nxt = ST_READ;
        else if (wd_expired) state_nxt = ST_HALT;
      end
      ST_READ: begin
        CHK_BUSY    = 1'b1;
        RD_FIFO_REQ = 1'b1;
        if (burst_end) state_nxt = last_burst ? ST_FLUSH : ST_WAIT;
      end
      // the final word's data arrives one cycle after its request
      ST_FLUSH: begin
        CHK_BUSY  = 1'b1;
        state_nxt = ST_HALT;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      idle_cnt    <= '0;
      beat_cnt    <= '0;
      burst_num   <= '0;
      rd_vld      <= 1'b0;
      CHK_DONE    <= 1'b0;
      CHK_ERR     <= 1'b0;
      ERR_CNT     <= '0;
      CHK_TIMEOUT <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= RD_FIFO_REQ;
      if (state == ST_WAIT) begin
        if (fifo_ready)      idle_cnt    <= '0;
        else if (wd_expired) CHK_TIMEOUT <= 1'b1;
        else                 idle_cnt    <= idle_cnt + IDLE_W'(1);
      end
      if (state == ST_READ) begin
        beat_cnt <= beat_cnt + BL_LOG2'(1);
        if (burst_end) burst_num <= burst_num + BURSTS_W'(1);
      end
      if (mismatch) begin
        CHK_ERR <= 1'b1;
        if (ERR_CNT != ERR_CNT_MAX) ERR_CNT <= ERR_CNT + 16'd1;
      end
      if (rd_vld && last_word) CHK_DONE <= 1'b1;
    end
  end

`ifdef CHK_ERR_CAPTURE_EN
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_FIRST_IDX  <= '0;
      ERR_FIRST_DATA <= '0;
    end else if (mismatch && !CHK_ERR) begin
      ERR_FIRST_IDX  <= word_idx;
      ERR_FIRST_DATA <= RD_FIFO_DATA;
    end
  end
`else
  assign ERR_FIRST_IDX  = '0;
  assign ERR_FIRST_DATA = '0;
`endif

endmodule
